// File: rtl/btb_repair_scheduler.sv
// btb_repair_scheduler: arbitrates front-end and FIFO-buffered back-end BTB repairs and runs a full-BTB clear sweep
module btb_repair_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ENTRY_NUM  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fe_valid_i,
  input  logic [31:0] fe_vaddr_i,
  input  logic        fe_take_i,
  input  logic [31:0] fe_dest_i,
  input  logic        be_valid_i,
  output logic        be_ready_o,
  input  logic [31:0] be_vaddr_i,
  input  logic        be_take_i,
  input  logic [31:0] be_dest_i,
  input  logic        clr_req_i,
  output logic        clr_busy_o,
  output logic        wr_en_o,
  output logic [31:0] wr_vaddr_o,
  output logic        wr_take_o,
  output logic [31:0] wr_dest_o,
  output logic [7:0]  drop_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(ENTRY_NUM) + 2;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [31:0] r_vaddr_q [FIFO_DEPTH];
  logic        r_take_q  [FIFO_DEPTH];
  logic [31:0] r_dest_q  [FIFO_DEPTH];
  logic [AW:0] r_wptr, r_rptr;
  logic        r_wr_en, r_wr_take;
  logic [31:0] r_wr_vaddr, r_wr_dest;
  logic [7:0]  r_drop;
  logic        w_idle, w_empty, w_full, w_fe_wr, w_pop, w_push, w_drop, w_sweep, w_wr, w_wr_take;
  logic [31:0] w_wr_vaddr, w_wr_dest;
  assign w_idle     = r_state == IDLE;
  assign w_empty    = r_wptr == r_rptr;
  assign w_full     = (r_wptr - r_rptr) == (AW+1)'(FIFO_DEPTH);
  assign w_fe_wr    = w_idle && fe_valid_i && !clr_req_i;
  assign w_pop      = w_idle && !fe_valid_i && !clr_req_i && !w_empty;
  assign w_sweep    = !w_idle && !clr_req_i;
  assign w_drop     = fe_valid_i && (!w_idle || clr_req_i);
  assign be_ready_o = w_idle && !clr_req_i && !w_full;
  assign w_push     = be_valid_i && be_ready_o;
  assign w_wr       = w_fe_wr || w_pop || w_sweep;
  assign clr_busy_o = !w_idle;
  assign wr_en_o    = r_wr_en;
  assign wr_vaddr_o = r_wr_vaddr;
  assign wr_take_o  = r_wr_take;
  assign wr_dest_o  = r_wr_dest;
  assign drop_cnt_o = r_drop;
  always_comb begin
    w_state_nxt = clr_req_i ? CLEAR : (!w_idle && r_cnt != '1) ? CLEAR : IDLE;
    w_cnt_nxt   = w_sweep ? r_cnt + 1'b1 : '0;
    w_wr_vaddr  = w_sweep ? 32'({r_cnt, 2'b00}) : w_fe_wr ? fe_vaddr_i : r_vaddr_q[r_rptr[AW-1:0]];
    w_wr_take   = w_sweep ? 1'b0 : w_fe_wr ? fe_take_i : r_take_q[r_rptr[AW-1:0]];
    w_wr_dest   = w_sweep ? 32'd0 : w_fe_wr ? fe_dest_i : r_dest_q[r_rptr[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_vaddr_q[r_wptr[AW-1:0]] <= be_vaddr_i;
      r_take_q[r_wptr[AW-1:0]]  <= be_take_i;
      r_dest_q[r_wptr[AW-1:0]]  <= be_dest_i;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_wr_en    <= 1'b0;
      r_wr_vaddr <= '0;
      r_wr_take  <= 1'b0;
      r_wr_dest  <= '0;
      r_drop     <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_wr_en <= w_wr;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      if (w_wr) begin
        r_wr_vaddr <= w_wr_vaddr;
        r_wr_take  <= w_wr_take;
        r_wr_dest  <= w_wr_dest;
      end
      if (w_drop && r_drop != 8'hff) r_drop <= r_drop + 1'b1;
    end
  end
endmodule

// File: tb/tb_btb_repair_scheduler.sv
// tb_btb_repair_scheduler: directed self-checking bench for btb_repair_scheduler
module tb_btb_repair_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fe_valid = 1'b0, fe_take = 1'b0, be_valid = 1'b0, be_take = 1'b0, clr_req = 1'b0;
  logic [31:0] fe_vaddr = '0, fe_dest = '0, be_vaddr = '0, be_dest = '0;
  logic        be_ready, clr_busy, wr_en, wr_take;
  logic [31:0] wr_vaddr, wr_dest;
  logic [7:0]  drop_cnt;
  int          n_chk = 0, n_pass = 0, n_wr;
  logic [31:0] seq [128];
  always #5 clk = ~clk;
  btb_repair_scheduler dut (
    .clk(clk), .rst(rst),
    .fe_valid_i(fe_valid), .fe_vaddr_i(fe_vaddr), .fe_take_i(fe_take), .fe_dest_i(fe_dest),
    .be_valid_i(be_valid), .be_ready_o(be_ready), .be_vaddr_i(be_vaddr), .be_take_i(be_take), .be_dest_i(be_dest),
    .clr_req_i(clr_req), .clr_busy_o(clr_busy),
    .wr_en_o(wr_en), .wr_vaddr_o(wr_vaddr), .wr_take_o(wr_take), .wr_dest_o(wr_dest),
    .drop_cnt_o(drop_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic set_fe(input logic v, input int i);
    fe_valid = v;
    fe_vaddr = 32'h1000_0000 + 32'(i) * 16;
    fe_take  = i[0];
    fe_dest  = fe_vaddr + 32'h100;
  endtask
  task automatic set_be(input logic v, input int i);
    be_valid = v;
    be_vaddr = 32'h2000_0000 + 32'(i) * 16;
    be_take  = ~i[0];
    be_dest  = be_vaddr + 32'h300;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_en", wr_en, 0);
    chk("rst_vaddr", wr_vaddr, 0);
    chk("rst_take", wr_take, 0);
    chk("rst_dest", wr_dest, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_busy", clr_busy, 0);
    rst = 1'b0;
    #1 chk("rst_ready", be_ready, 1);
    tick;
    fe_valid = 1'b1;
    fe_vaddr = 32'h8000_0104;
    fe_take  = 1'b1;
    fe_dest  = 32'h8000_0200;
    tick;
    fe_valid = 1'b0;
    chk("fe_en", wr_en, 1);
    chk("fe_vaddr", wr_vaddr, 32'h8000_0104);
    chk("fe_take", wr_take, 1);
    chk("fe_dest", wr_dest, 32'h8000_0200);
    tick;
    chk("fe_en_off", wr_en, 0);
    chk("fe_hold", wr_vaddr, 32'h8000_0104);
    for (int i = 0; i < 5; i++) begin
      set_be(i < 3, i);
      #1 if (i < 3) chk("be_ready", be_ready, 1);
      tick;
      chk("be_en", wr_en, (i >= 1 && i <= 3) ? 1 : 0);
      if (i >= 1 && i <= 3) begin
        chk("be_vaddr", wr_vaddr, 32'h2000_0000 + 32'(i - 1) * 16);
        chk("be_take", wr_take, (i - 1) % 2 == 0 ? 1 : 0);
        chk("be_dest", wr_dest, 32'h2000_0300 + 32'(i - 1) * 16);
      end
    end
    for (int i = 0; i < 11; i++) begin
      set_fe(i < 5, i);
      set_be(i < 5, i);
      #1;
      if (i < 5) chk("fill_ready", be_ready, i < 4 ? 1 : 0);
      if (i == 5) chk("full_ready", be_ready, 0);
      if (i == 6) chk("drain_ready", be_ready, 1);
      tick;
      chk("prio_en", wr_en, i < 9 ? 1 : 0);
      if (i < 5) chk("prio_fe", wr_vaddr, 32'h1000_0000 + 32'(i) * 16);
      else if (i < 9) begin
        chk("prio_be", wr_vaddr, 32'h2000_0000 + 32'(i - 5) * 16);
        chk("prio_be_dest", wr_dest, 32'h2000_0300 + 32'(i - 5) * 16);
      end
    end
    set_fe(1'b1, 7);
    set_be(1'b1, 9);
    tick;
    set_fe(1'b0, 0);
    set_be(1'b0, 0);
    clr_req = 1'b1;
    #1 chk("clr_ready", be_ready, 0);
    tick;
    clr_req = 1'b0;
    chk("pre_clr_fe", wr_vaddr, 32'h1000_0070);
    for (int k = 0; k < 65; k++) begin
      fe_valid = (k == 10);
      #1;
      chk("sweep_busy", clr_busy, k < 64 ? 1 : 0);
      if (k < 64) chk("sweep_ready", be_ready, 0);
      tick;
      chk("sweep_en", wr_en, 1);
      if (k < 64) begin
        chk("sweep_vaddr", wr_vaddr, 32'(k) * 4);
        chk("sweep_take", wr_take, 0);
        chk("sweep_dest", wr_dest, 0);
      end else begin
        chk("retain_vaddr", wr_vaddr, 32'h2000_0090);
        chk("retain_take", wr_take, 0);
      end
    end
    fe_valid = 1'b0;
    chk("drop_one", drop_cnt, 1);
    chk("sweep_done", clr_busy, 0);
    clr_req = 1'b1;
    tick;
    clr_req = 1'b0;
    n_wr = 0;
    for (int j = 1; j <= 100; j++) begin
      if (wr_en && n_wr < 128) begin
        seq[n_wr] = wr_vaddr;
        n_wr++;
      end
      clr_req = (j == 31);
      tick;
    end
    chk("restart_count", n_wr, 94);
    chk("restart_first", seq[0], 32'h00);
    chk("restart_before", seq[29], 32'h74);
    chk("restart_zero", seq[30], 32'h00);
    chk("restart_last", seq[93], 32'hfc);
    chk("restart_done", clr_busy, 0);
    clr_req  = 1'b1;
    fe_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick;
    clr_req  = 1'b0;
    fe_valid = 1'b0;
    chk("drop_sat", drop_cnt, 255);
    for (int i = 0; i < 10; i++) tick;
    chk("mid_en", wr_en, 1);
    chk("mid_busy", clr_busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("abort_en", wr_en, 0);
    chk("abort_busy", clr_busy, 0);
    chk("abort_drop", drop_cnt, 0);
    chk("abort_vaddr", wr_vaddr, 0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("abort_quiet", wr_en, 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
